// File: rtl/mux41_sched_pkg.sv
// Shared types and sizes for the round-robin mux scheduler.
package mux41_sched_pkg;

  localparam int N_REQ  = 4;
  localparam int SEL_W  = 2;
  localparam int DATA_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mux41_rr_sched_rr_pick.sv
// Rotating-priority picker: first requester at or after ptr, wrapping modulo 4.
module rr_pick
  import mux41_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest candidate back to ptr so the closest request wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_41.sv
// 4:1 selector of 4-bit words; channel index is {s0,s1} with s0 as the MSB.
module mux_41 (
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  input  logic       s0,
  input  logic       s1,
  output logic [3:0] out
);

  // Decode the two select lines into one of the four inputs.
  always_comb begin
    case ({s0, s1})
      2'b00:   out = in0;
      2'b01:   out = in1;
      2'b10:   out = in2;
      default: out = in3;
    endcase
  end

endmodule

// File: rtl/mux41_rr_sched.sv
// Round-robin scheduler sharing one mux_41 between four valid/ready/last requesters.
module mux41_rr_sched
  import mux41_sched_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int PTR_RESET = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_valid,
  input  logic [N_REQ-1:0]  req_last,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  output logic [N_REQ-1:0]  req_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              s0,
  output logic              s1,
  output logic [N_REQ-1:0]  grant,
  output logic              busy
);

  // Counter holds 0..MAX_BURST-1 within a burst; with MAX_BURST 0 it simply wraps.
  localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST) + 1 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
  localparam logic [SEL_W-1:0] PTR_INIT = SEL_W'(PTR_RESET);

  state_t           state, state_n;
  logic [N_REQ-1:0] grant_n;
  logic [SEL_W-1:0] sel, sel_n;
  logic [SEL_W-1:0] rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_n;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             burst_end;
  logic             transfer;

  rr_pick u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  mux_41 u_mux (
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .s0  (s0),
    .s1  (s1),
    .out (out_data)
  );

  assign s0 = sel[1];
  assign s1 = sel[0];

  // Handshake outputs follow the owning channel; everything is quiet while idle.
  always_comb begin
    busy      = (state == GRANT);
    burst_end = (MAX_BURST != 0) && (beat_cnt == CNT_LAST);
    out_valid = busy && req_valid[sel];
    out_last  = busy && (req_last[sel] || burst_end);
    req_ready = '0;
    if (busy) req_ready[sel] = out_ready;
    transfer  = out_valid && out_ready;
  end

  // Arbitrate when idle; count beats and release on a last beat when granted.
  always_comb begin
    state_n    = state;
    grant_n    = grant;
    sel_n      = sel;
    rr_ptr_n   = rr_ptr;
    beat_cnt_n = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_n    = GRANT;
          grant_n    = N_REQ'(1) << pick_idx;
          sel_n      = pick_idx;
          beat_cnt_n = '0;
        end
      end
      default: begin
        if (transfer) begin
          beat_cnt_n = beat_cnt + CNT_W'(1);
          if (out_last) begin
            state_n    = IDLE;
            grant_n    = '0;
            rr_ptr_n   = sel + SEL_W'(1);
            beat_cnt_n = '0;
          end
        end
      end
    endcase
  end

  // State, ownership, selects, pointer and beat counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      rr_ptr   <= PTR_INIT;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      sel      <= sel_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_cnt_n;
    end
  end

endmodule

// File: tb/tb_mux41_rr_sched.sv
// Self-checking bench for mux41_rr_sched against a rule-level scheduler model.
module tb_mux41_rr_sched;

  localparam int MB = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req_valid;
  logic [3:0] req_last;
  logic [3:0] in_data [4];
  logic [3:0] req_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       s0;
  logic       s1;
  logic [3:0] grant;
  logic       busy;

  int tests_run = 0;
  int fail_count = 0;

  // Model of the scheduler rules: owner -1 means idle.
  int m_owner;
  int m_ptr;
  int m_cnt;
  int m_sel;

  mux41_rr_sched #(.MAX_BURST(MB), .PTR_RESET(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .in0       (in_data[0]),
    .in1       (in_data[1]),
    .in2       (in_data[2]),
    .in3       (in_data[3]),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .s0        (s0),
    .s1        (s1),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_sel   = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelEdge();
    bit found;
    bit is_last;
    found = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (!found && req_valid[j]) begin
          found   = 1;
          m_owner = j;
          m_sel   = j;
          m_cnt   = 0;
        end
      end
    end else if (req_valid[m_owner] && out_ready) begin
      is_last = req_last[m_owner] || (MB != 0 && m_cnt == MB - 1);
      m_cnt++;
      if (is_last) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_cnt   = 0;
      end
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      fail_count++;
      $error("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic checkOutput();
    int o;
    bit b;
    logic [3:0] e_grant, e_ready;
    o = (m_owner < 0) ? 0 : m_owner;
    b = (m_owner >= 0);
    e_grant = b ? 4'(1 << o) : 4'h0;
    e_ready = (b && out_ready) ? 4'(1 << o) : 4'h0;
    check4("busy",      {3'b0, busy},      {3'b0, b});
    check4("grant",     grant,             e_grant);
    check4("sel",       {2'b0, s0, s1},    4'(m_sel));
    check4("out_valid", {3'b0, out_valid}, {3'b0, b && req_valid[o]});
    check4("out_last",  {3'b0, out_last},
           {3'b0, b && (req_last[o] || (MB != 0 && m_cnt == MB - 1))});
    check4("req_ready", req_ready,         e_ready);
    check4("out_data",  out_data,          in_data[m_sel]);
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic r);
    req_valid = v;
    req_last  = l;
    out_ready = r;
  endtask

  // Check mid-cycle, then let the edge happen and advance the model with it.
  task automatic step();
    #2;
    checkOutput();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    modelReset();
    #2;
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) in_data[i] = 4'(i + 8);
    #1;
    doReset();

    // Single channel 2 burst of three beats carrying 4'h3.
    in_data[2] = 4'h3;
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    step();
    step();
    step();
    applyStimulus(4'b0100, 4'b0100, 1'b1);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    step();
    check4("ptr_after_t1", 4'(m_ptr), 4'h3);

    // Everyone requesting single-beat bursts: rotation with bubbles.
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    for (int i = 0; i < 10; i++) step();

    // Channel 1 never flags last, channel 2 waiting: forced release at MB beats.
    doReset();
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    step();
    applyStimulus(4'b0110, 4'b0000, 1'b1);
    for (int i = 0; i < MB + 3; i++) step();
    check4("ch2_after_forced", grant, 4'b0100);

    // Downstream stall mid-burst.
    applyStimulus(4'b0110, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) step();
    applyStimulus(4'b0110, 4'b0000, 1'b1);
    step();
    step();

    // Asynchronous reset in the middle of a burst.
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput();
    check4("rst_grant", grant, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    step();
    step();
    check4("ch0_after_rst", grant, 4'b0001);

    // Granted channel 3 drops valid mid-burst then resumes.
    doReset();
    applyStimulus(4'b1000, 4'b0000, 1'b1);
    step();
    step();
    applyStimulus(4'b0111, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) step();
    applyStimulus(4'b1000, 4'b1000, 1'b1);
    step();
    step();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                    1'($urandom_range(0, 3) != 0));
      for (int c = 0; c < 4; c++) in_data[c] = 4'($urandom_range(0, 15));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
